// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the matching receiver.
//   tx_state_e : transmitter FSM encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4)
//   DATA_BITS  : data bits per frame
//   STOP_BITS  : stop bits per frame
//   calc_div() : clock cycles per bit period, truncated
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int calc_div(input int clkFreqHz, input int baud);
    return clkFreqHz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with occupancy count, shared by the UART TX and RX.
// Ports:
//   clk     : clock, rising edge
//   rstn    : asynchronous active-low reset, clears pointers and level
//   push_i  : write data_i (ignored while full)
//   data_i  : write data
//   pop_i   : discard the head entry (ignored while empty)
//   data_o  : head entry, valid while empty_o is low
//   level_o : number of stored entries, 0..DEPTH
//   full_o  : level_o == DEPTH
//   empty_o : level_o == 0
// DEPTH must be a power of two so the pointers wrap by simple overflow.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [LW-1:0]    level_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign data_o  = mem_q[rdPtr_q];
  assign level_o = level_q;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers wrap naturally; a simultaneous push and pop leaves the level alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stim.sv
// uart_tx_stim: byte-oriented UART transmitter, 8N1 (8E1/8O1 with parity).
// Ports:
//   clk     : core clock, rising edge
//   rstn    : asynchronous active-low reset
//   i_data  : byte to send, sampled only on a handshake
//   i_valid : i_data valid
//   o_ready : FIFO can accept a byte (push on i_valid & o_ready)
//   o_tx    : serial line, idle high, registered
//   o_busy  : a frame is on the line or the FIFO holds data
//   o_level : FIFO occupancy
// Optional feature: define UART_TX_PARITY_EN to add a parity bit between the
// data and stop bits; parameter PARITY_ODD (only then) selects odd parity.
module uart_tx_stim
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_stim: CLK_FREQ_HZ/BAUD must be at least 2");
  end

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  baudCnt_q, baudCnt_d;
  logic [2:0]     bitCnt_q, bitCnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           bitTick;
  logic           loadFrame;
  logic           fifoPop;
  logic [7:0]     fifoData;
  logic [LW-1:0]  fifoLevel;
  logic           fifoFull;
  logic           fifoEmpty;
`ifdef UART_TX_PARITY_EN
  logic           parity_q, parity_d;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (i_valid & ~fifoFull),
    .data_i  (i_data),
    .pop_i   (fifoPop),
    .data_o  (fifoData),
    .level_o (fifoLevel),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign bitTick = (baudCnt_q == CW'(DIV - 1));
  assign o_ready = ~fifoFull;
  assign o_level = fifoLevel;
  assign o_busy  = (state_q != ST_IDLE) | ~fifoEmpty;
  assign o_tx    = tx_q;

  // Next-state logic. The line level is computed from the current state and
  // registered, so o_tx trails the state by one cycle but every bit still
  // lasts exactly DIV cycles. Loading a frame (from IDLE or at the end of a
  // stop bit) is shared so back-to-back frames have no idle gap.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = bitTick ? '0 : baudCnt_q + 1'b1;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    loadFrame = 1'b0;
    fifoPop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        baudCnt_d = '0;
        if (!fifoEmpty) loadFrame = 1'b1;
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bitTick) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bitTick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bitCnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_d = parity_q;
        if (bitTick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (bitTick) begin
          if (!fifoEmpty) loadFrame = 1'b1;
          else            state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (loadFrame) begin
      fifoPop   = 1'b1;
      shift_d   = fifoData;
      bitCnt_d  = '0;
      baudCnt_d = '0;
      state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d  = (^fifoData) ^ PARITY_ODD;
`endif
    end
  end

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_stim.sv
// tb_uart_tx_stim: scoreboard bench for uart_tx_stim at DIV = 1600/100 = 16.
// Every accepted byte is queued as expected; an independent line decoder
// recovers frames from o_tx and compares them with the queue head.
// Honours UART_TX_PARITY_EN (even parity expected).
module tb_uart_tx_stim;

  localparam int DIV        = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * DIV;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic [2:0] o_level;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] expQ[$];
  int         startQ[$];
  int         framesSeen = 0;
  bit         inFrame = 1'b0;
  int         peakLevel = 0;
  bit         sawLow = 1'b0;

  uart_tx_stim #(
    .CLK_FREQ_HZ (1600),
    .BAUD        (100),
    .FIFO_DEPTH  (FIFO_DEPTH)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD  (1'b0)
`endif
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_tx    (o_tx),
    .o_busy  (o_busy),
    .o_level (o_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Main-thread clock step that also tracks FIFO peak and line activity.
  task automatic tick();
    @(negedge clk);
    if (int'(o_level) > peakLevel) peakLevel = int'(o_level);
    if (o_tx === 1'b0) sawLow = 1'b1;
  endtask

  // Offer one byte and hold it until accepted; returns at the negedge after the push edge.
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    i_data  = b;
    i_valid = 1'b1;
    while (o_ready !== 1'b1 && waited < 20 * FRAME) begin
      tick();
      waited++;
    end
    if (o_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL push_timeout: o_ready=%b required 1", o_ready);
      i_valid = 1'b0;
      return;
    end
    expQ.push_back(b);
    tick();
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || inFrame || o_busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_done", (expQ.size() != 0 || inFrame || o_busy !== 1'b0), 0);
  endtask

  task automatic waitNeg(input int n, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        aborted = 1'b1;
        return;
      end
    end
  endtask

  // Line decoder: finds a start bit, samples each bit mid-period, compares with the scoreboard.
  initial begin : monitor
    bit         ab;
    int         st;
    logic [7:0] b;
    logic [7:0] e;
    logic       stopBit;
    logic       parBit;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && o_tx === 1'b0) begin
        st      = cyc;
        inFrame = 1'b1;
        b       = '0;
        parBit  = 1'b0;
        stopBit = 1'b0;
        waitNeg(DIV / 2, ab);
        if (!ab) checkOutput("start_bit", o_tx, 0);
        for (int i = 0; i < 8; i++) begin
          if (!ab) waitNeg(DIV, ab);
          if (!ab) b[i] = o_tx;
        end
`ifdef UART_TX_PARITY_EN
        if (!ab) waitNeg(DIV, ab);
        if (!ab) parBit = o_tx;
`endif
        if (!ab) waitNeg(DIV, ab);
        if (!ab) stopBit = o_tx;
        if (!ab) begin
          framesSeen++;
          startQ.push_back(st);
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_frame: got byte %0h, none expected", b);
          end else begin
            e = expQ.pop_front();
            checkOutput("frame_byte", b, e);
            checkOutput("stop_bit", stopBit, 1);
`ifdef UART_TX_PARITY_EN
            checkOutput("parity_bit", parBit, ^e);
`endif
          end
        end
        inFrame = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    int sz;
    int f0;
    rstn    = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    $display("[TB] reset state");
    checkOutput("reset_tx", o_tx, 1);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_level", o_level, 0);
    checkOutput("reset_ready", o_ready, 1);

    $display("[TB] single byte A5");
    applyStimulus(8'hA5);
    i_valid = 1'b0;
    n = cyc;
    checkOutput("a5_level_after_push", o_level, 1);
    checkOutput("a5_tx_idle_edge_n", o_tx, 1);
    tick();
    checkOutput("a5_level_after_pop", o_level, 0);
    checkOutput("a5_tx_idle_edge_n1", o_tx, 1);
    checkOutput("a5_busy", o_busy, 1);
    tick();
    checkOutput("a5_tx_start_edge_n2", o_tx, 0);
    while (cyc < n + FRAME) tick();
    checkOutput("a5_busy_last_stop_cycle", o_busy, 1);
    tick();
    checkOutput("a5_busy_fall", o_busy, 0);
    waitDrain(4 * FRAME);
    checkOutput("a5_start_cycle", startQ[startQ.size() - 1], n + 2);

    $display("[TB] back-to-back 00 FF");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    i_valid = 1'b0;
    waitDrain(4 * FRAME);
    sz = startQ.size();
    checkOutput("b2b_start_spacing", startQ[sz - 1] - startQ[sz - 2], FRAME);

    $display("[TB] full FIFO, six bytes");
    peakLevel = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(8'($urandom));
      if (k == 4) begin
        checkOutput("full_level_after_5th", o_level, FIFO_DEPTH);
        checkOutput("full_ready_low", o_ready, 0);
      end
    end
    i_valid = 1'b0;
    waitDrain(10 * FRAME);
    checkOutput("full_peak_level", peakLevel, FIFO_DEPTH);
    sz = startQ.size();
    checkOutput("full_contiguous", startQ[sz - 1] - startQ[sz - 6], 5 * FRAME);

    $display("[TB] reset during bit 3 of 3C");
    applyStimulus(8'h3C);
    i_valid = 1'b0;
    n = cyc;
    while (cyc < n + 2 + 4 * DIV + DIV / 2) tick();
    #3;
    rstn = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_bit3_tx", o_tx, 1);
    checkOutput("rst_bit3_level", o_level, 0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    checkOutput("rst_release_level", o_level, 0);
    checkOutput("rst_release_busy", o_busy, 0);
    checkOutput("rst_release_ready", o_ready, 1);
    f0 = framesSeen;
    sawLow = 1'b0;
    repeat (2 * FRAME) tick();
    checkOutput("rst_no_residual_frame", framesSeen, f0);
    checkOutput("rst_line_stays_idle", sawLow, 0);

    $display("[TB] reset during start bit");
    applyStimulus(8'($urandom));
    i_valid = 1'b0;
    n = cyc;
    while (cyc < n + 2 + DIV / 2) tick();
    checkOutput("rst_start_tx_low", o_tx, 0);
    #3;
    rstn = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_start_tx_async", o_tx, 1);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    checkOutput("rst_start_busy", o_busy, 0);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity 07 and 03");
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    i_valid = 1'b0;
    waitDrain(4 * FRAME);
    sz = startQ.size();
    checkOutput("parity_frame_length", startQ[sz - 1] - startQ[sz - 2], 11 * DIV);
`endif

    $display("[TB] random bytes with random gaps");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(8'($urandom));
      i_valid = 1'b0;
      n = $urandom_range(0, 2 * FRAME);
      for (int g = 0; g < n; g++) begin
        i_data = 8'($urandom);
        tick();
      end
    end
    waitDrain(12 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
